// File: rtl/data_mem_responder_pkg.sv
// Shared constants for the data-memory responder: FSM encodings
// and default geometry/latency.
package data_mem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int DEF_DEPTH   = 1024;
    localparam int DEF_LATENCY = 2;

endpackage

// File: rtl/data_mem_responder_mem_latency_counter.sv
// 4-bit down-counter that times the access latency; reloaded
// on acceptance and decremented while the FSM waits.
module mem_latency_counter #(
    parameter logic [3:0] INIT = 4'd1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       dec,
    output logic [3:0] cnt,
    output logic       zero
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= 4'd0;
        end else if (load) begin
            cnt <= INIT;
        end else if (dec && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    assign zero = (cnt == 4'd0);

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: 4-phase req/ack, fixed programmable latency.
// Define DMEM_ERR_CHECK_EN to flag misaligned/out-of-range accesses.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ack,
    output logic [DATA_W-1:0] rdata,
    output logic              err
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state, state_n;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              ack_n, err_n;
    logic [DATA_W-1:0] rdata_n;
    logic              cnt_load, cnt_dec, cnt_zero;
    logic [3:0]        cnt;
    logic              mem_we;
    logic [ADDR_W-1:0] word;
    logic [IW-1:0]     idx;
    logic              fault;

    assign word = addr_q >> 2;
    assign idx  = IW'(word % ADDR_W'(DEPTH));

`ifdef DMEM_ERR_CHECK_EN
    assign fault = (addr_q[1:0] != 2'b00) || (word >= ADDR_W'(DEPTH));
`else
    assign fault = 1'b0;
`endif

    mem_latency_counter #(
        .INIT (4'(LATENCY - 1))
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .load (cnt_load),
        .dec  (cnt_dec),
        .cnt  (cnt),
        .zero (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            ack     <= 1'b0;
            err     <= 1'b0;
            rdata   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state <= state_n;
            ack   <= ack_n;
            err   <= err_n;
            rdata <= rdata_n;
            if (cnt_load) begin
                we_q    <= we;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
        end
    end

    // No reset: preloaded contents must survive rst.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx] <= wdata_q;
        end
    end

    always_comb begin
        state_n  = state;
        ack_n    = ack;
        err_n    = err;
        rdata_n  = rdata;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        mem_we   = 1'b0;
        unique case (state)
            IDLE: begin
                if (req) begin
                    cnt_load = 1'b1;
                    state_n  = WAIT;
                end
            end
            WAIT: begin
                if (!cnt_zero) begin
                    cnt_dec = 1'b1;
                end else begin
                    state_n = RESP;
                    ack_n   = 1'b1;
                    err_n   = fault;
                    if (we_q) begin
                        mem_we = !fault;
                    end else begin
                        rdata_n = fault ? '0 : mem[idx];
                    end
                end
            end
            RESP: begin
                if (!req) begin
                    ack_n   = 1'b0;
                    err_n   = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    wire unused_cnt = ^cnt;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder
// (LATENCY=2 instance plus a LATENCY=1 instance).
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0, we = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic        ack, err;
    logic [31:0] rdata;

    logic        req1 = 1'b0;
    logic        ack1, err1;
    logic [31:0] rdata1;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    data_mem_responder #(.LATENCY(2)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr),
        .wdata(wdata), .ack(ack), .rdata(rdata), .err(err)
    );

    data_mem_responder #(.LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .req(req1), .we(1'b0), .addr(32'h0000_000C),
        .wdata(32'h0), .ack(ack1), .rdata(rdata1), .err(err1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Raise req at a negedge and count negedges until ack is seen.
    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         output int lat);
        req = 1'b1; we = w; addr = a; wdata = d;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!ack && lat < 20);
    endtask

    task automatic release_req(input string tag);
        req = 1'b0;
        @(negedge clk);
        chk(tag, 32'(ack), 32'd0);
    endtask

    int lat;
    int t_first;
    int t_second;

    initial begin
        #2;
        chk("reset_ack", 32'(ack), 32'd0);
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_err", 32'(err), 32'd0);
        dut.mem[1] = 32'h0000_5555;
        dut.mem[3] = 32'hDEAD_BEEF;
        dut.mem[4] = 32'h1111_1111;
        dut1.mem[3] = 32'hCAFE_F00D;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Load with LATENCY=2
        issue(1'b0, 32'h0000_000C, 32'h0, lat);
        chk("load_latency", 32'(lat), 32'd3);
        chk("load_ack", 32'(ack), 32'd1);
        chk("load_rdata", rdata, 32'hDEAD_BEEF);
        chk("load_err", 32'(err), 32'd0);
        release_req("load_ack_drop");
        chk("load_rdata_held", rdata, 32'hDEAD_BEEF);
        @(negedge clk);

        // Store then load
        issue(1'b1, 32'h0000_0020, 32'h1234_5678, lat);
        chk("store_latency", 32'(lat), 32'd3);
        chk("store_rdata_unchanged", rdata, 32'hDEAD_BEEF);
        release_req("store_ack_drop");
        @(negedge clk);
        issue(1'b0, 32'h0000_0020, 32'h0, lat);
        chk("st_ld_rdata", rdata, 32'h1234_5678);
        chk("st_ld_err", 32'(err), 32'd0);
        release_req("st_ld_ack_drop");
        @(negedge clk);

        // Hold req 5 cycles after ack; toggle inputs during WAIT
        req = 1'b1; we = 1'b0; addr = 32'h0000_000C; wdata = 32'h0;
        @(negedge clk);
        we = 1'b1; addr = 32'h0000_0020; wdata = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("hold_not_yet", 32'(ack), 32'd0);
        @(negedge clk);
        chk("hold_ack", 32'(ack), 32'd1);
        chk("hold_rdata", rdata, 32'hDEAD_BEEF);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("hold_ack_%0d", i), 32'(ack), 32'd1);
        end
        chk("hold_no_store", dut.mem[8], 32'h1234_5678);
        chk("hold_addr0_intact", dut.mem[3], 32'hDEAD_BEEF);
        release_req("hold_ack_drop");
        @(negedge clk);

        // Wrap / fault
        issue(1'b1, 32'h0000_1004, 32'h0000_00A5, lat);
        chk("wrap_ack", 32'(ack), 32'd1);
`ifdef DMEM_ERR_CHECK_EN
        chk("wrap_err", 32'(err), 32'd1);
        release_req("wrap_ack_drop");
        chk("wrap_err_clear", 32'(err), 32'd0);
        chk("wrap_mem", dut.mem[1], 32'h0000_5555);
        @(negedge clk);
        issue(1'b0, 32'h0000_000E, 32'h0, lat);
        chk("misalign_err", 32'(err), 32'd1);
        chk("misalign_rdata", rdata, 32'h0);
        release_req("misalign_ack_drop");
`else
        chk("wrap_err", 32'(err), 32'd0);
        release_req("wrap_ack_drop");
        chk("wrap_mem", dut.mem[1], 32'h0000_00A5);
`endif
        @(negedge clk);

        // LATENCY=1 back-to-back
        req1 = 1'b1;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!ack1 && lat < 20);
        t_first = cyc;
        chk("l1_latency", 32'(lat), 32'd2);
        chk("l1_rdata", rdata1, 32'hCAFE_F00D);
        req1 = 1'b0;
        @(negedge clk);
        chk("l1_ack_drop", 32'(ack1), 32'd0);
        req1 = 1'b1;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!ack1 && lat < 20);
        t_second = cyc;
        chk("l1_spacing", 32'(t_second - t_first), 32'd3);
        req1 = 1'b0;
        @(negedge clk);

        // Async reset mid-WAIT of a store to 0x10
        req = 1'b1; we = 1'b1; addr = 32'h0000_0010; wdata = 32'h9999_9999;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_rdata", rdata, 32'h0);
        req = 1'b0; we = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_mem_kept", dut.mem[4], 32'h1111_1111);
        chk("rst_idle_ack", 32'(ack), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
